// File: rtl/sel21_pkg.sv
// Shared definitions for the sel21_arb round-robin select controller:
// state encoding and default dwell limits.
package sel21_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } state_t;

  localparam int HOLD_MIN_DEF = 4;
  localparam int MAX_HOLD_DEF = 16;

endpackage

// File: rtl/sel21_dwell_cnt.sv
// Dwell counter for the current grant: synchronous clear, enable and
// saturation at MAX_HOLD-1, with minimum-dwell and timeout flags.
module sel21_dwell_cnt #(
  parameter int CNT_W    = 8,
  parameter int HOLD_MIN = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             ge_min,
  output logic             at_max
);

  localparam logic [CNT_W-1:0] MIN_V = CNT_W'(HOLD_MIN - 1);
  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_HOLD - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != MAX_V)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign ge_min = (cnt >= MIN_V);
  assign at_max = (cnt == MAX_V);

endmodule

// File: rtl/sel21_arb.sv
// Round-robin select controller driving mux21 S1 with min-dwell/max-hold.
// Optional SEL21_ARB_STAT_EN adds SW_CNT, a saturating handover counter.
module sel21_arb
  import sel21_pkg::*;
#(
  parameter int HOLD_MIN = HOLD_MIN_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int CNT_W    = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       REQ0,
  input  logic       REQ1,
  input  logic       DONE,
  output logic       S1,
  output logic       GNT0,
  output logic       GNT1,
  output logic       BUSY
`ifdef SEL21_ARB_STAT_EN
  ,
  output logic [7:0] SW_CNT
`endif
);

  generate
    if (HOLD_MIN < 1 || MAX_HOLD < HOLD_MIN || MAX_HOLD > 255 || (2 ** CNT_W) <= MAX_HOLD) begin : g_bad_param
      $error("sel21_arb: illegal HOLD_MIN/MAX_HOLD/CNT_W combination");
    end
  endgenerate

  state_t           state_reg, state_next;
  logic             s1_reg, last_reg;
  logic             enter0, enter1;
  logic             rel0, rel1;
  logic             ge_min, at_max;
  logic [CNT_W-1:0] cnt;

  sel21_dwell_cnt #(
    .CNT_W   (CNT_W),
    .HOLD_MIN(HOLD_MIN),
    .MAX_HOLD(MAX_HOLD)
  ) u_dwell (
    .clk   (CLK),
    .rst_n (RST_N),
    .clr   (state_next != state_reg),
    .en    (state_reg != IDLE),
    .cnt   (cnt),
    .ge_min(ge_min),
    .at_max(at_max)
  );

  assign rel0 = (ge_min && (!REQ0 || DONE)) || (at_max && REQ1);
  assign rel1 = (ge_min && (!REQ1 || DONE)) || (at_max && REQ0);

  always_comb begin
    state_next = state_reg;
    enter0     = 1'b0;
    enter1     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (REQ0 && REQ1) begin
          enter0 = last_reg;
          enter1 = !last_reg;
        end else begin
          enter0 = REQ0;
          enter1 = REQ1;
        end
      end
      GRANT0: begin
        if (rel0) begin
          if (REQ1) enter1 = 1'b1;
          else      state_next = IDLE;
        end
      end
      GRANT1: begin
        if (rel1) begin
          if (REQ0) enter0 = 1'b1;
          else      state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (enter0) state_next = GRANT0;
    if (enter1) state_next = GRANT1;
  end

  // S1 and LAST only move when a grant is issued, so S1 parks in IDLE.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= IDLE;
      s1_reg    <= 1'b0;
      last_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      if (enter0 || enter1) begin
        s1_reg   <= enter1;
        last_reg <= enter1;
      end
    end
  end

  assign S1   = s1_reg;
  assign GNT0 = (state_reg == GRANT0);
  assign GNT1 = (state_reg == GRANT1);
  assign BUSY = (state_reg != IDLE);

`ifdef SEL21_ARB_STAT_EN
  logic [7:0] sw_cnt_reg;
  logic       handover;

  // A grant to the channel that did not own last time is a handover.
  assign handover = (enter0 && last_reg) || (enter1 && !last_reg);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sw_cnt_reg <= 8'd0;
    end else if (handover && (sw_cnt_reg != 8'hFF)) begin
      sw_cnt_reg <= sw_cnt_reg + 8'd1;
    end
  end

  assign SW_CNT = sw_cnt_reg;
`endif

endmodule
